medidor_periodo: RTL and testbench

Measures the period of an external beat/tap signal in clock cycles; the receive-side counterpart of the period counter that generates the beat. An asynchronous pulse input is synchronized and edge-detected, and the number of clock cycles between successive rising edges is counted. Each valid interval is published on `periodo` with a one-cycle `pronto` strobe. Sits between the user tap input and the tempo/period configuration logic; also used in loopback to check the generator.

---
 rtl/medidor_periodo_pkg.sv | 19 +
 rtl/sincronizador_borda.sv | 33 +++
 rtl/medidor_periodo.sv | 96 +++++++++
 tb/tb_medidor_periodo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/medidor_periodo_pkg.sv
// Shared definitions for the beat period meter and its companion period generator.
package medidor_periodo_pkg;

    // Measurement FSM states; the encoding is fixed so other blocks can decode it directly
    typedef enum logic [1:0] {
        ESPERA  = 2'b00,
        CONTA   = 2'b01,
        ESTOURO = 2'b10
    } estado_t;

    localparam int N_PADRAO   = 16;
    localparam int MIN_PADRAO = 4;

    // Largest period representable in a counter of the given width
    function automatic int periodo_maximo(input int largura);
        return (1 << largura) - 1;
    endfunction

endpackage

// File: rtl/sincronizador_borda.sv
// Brings an asynchronous input into the clock domain and flags its rising edges.
module sincronizador_borda (
    input  logic clock,
    input  logic zera_as,
    input  logic zera_s,
    input  logic entrada,
    output logic borda
);

    logic s1;
    logic s2;
    logic s3;

    // Two flops for metastability, a third as the previous value for edge detection
    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else if (zera_s) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= entrada;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign borda = s2 & ~s3;

endmodule

// File: rtl/medidor_periodo.sv
// Measures the number of clock cycles between successive rising edges of an external beat.
module medidor_periodo
    import medidor_periodo_pkg::*;
#(
    parameter int N   = N_PADRAO,
    parameter int MIN = MIN_PADRAO
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         habilita,
    input  logic         batida,
    output logic [N-1:0] periodo,
    output logic         pronto,
    output logic         estouro,
    output logic         medindo
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_MIN = N'(MIN);

    estado_t      estado;
    logic [N-1:0] cnt;
    logic         borda;

    sincronizador_borda u_sincronizador (
        .clock   (clock),
        .zera_as (zera_as),
        .zera_s  (zera_s),
        .entrada (batida),
        .borda   (borda)
    );

    // FSM, interval counter and capture register; overflow is reached before the counter could wrap
    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            estado  <= ESPERA;
            cnt     <= '0;
            periodo <= '0;
            pronto  <= 1'b0;
            estouro <= 1'b0;
        end else if (zera_s) begin
            estado  <= ESPERA;
            cnt     <= '0;
            periodo <= '0;
            pronto  <= 1'b0;
            estouro <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (!habilita) begin
                estado <= ESPERA;
                cnt    <= '0;
            end else begin
                case (estado)
                    ESPERA: begin
                        if (borda) begin
                            estado <= CONTA;
                            cnt    <= {{(N-1){1'b0}}, 1'b1};
                        end else begin
                            cnt <= '0;
                        end
                    end
                    CONTA: begin
                        if (borda && (cnt >= CNT_MIN)) begin
                            periodo <= cnt;
                            pronto  <= 1'b1;
                            estouro <= 1'b0;
                            cnt     <= {{(N-1){1'b0}}, 1'b1};
                        end else if (cnt == CNT_MAX) begin
                            estado  <= ESTOURO;
                            estouro <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ESTOURO: begin
                        if (borda) begin
                            estado <= CONTA;
                            cnt    <= {{(N-1){1'b0}}, 1'b1};
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        estado <= ESPERA;
                        cnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign medindo = (estado == CONTA);

endmodule

// File: tb/tb_medidor_periodo.sv
// Self-checking bench for medidor_periodo: timestamp-based reference model plus directed and random beats.
module tb_medidor_periodo;

    localparam int N    = 8;
    localparam int MIN  = 4;
    localparam int MAXP = 255;

    logic         clock    = 1'b0;
    logic         zera_as  = 1'b1;
    logic         zera_s   = 1'b0;
    logic         habilita = 1'b0;
    logic         batida   = 1'b0;
    logic [N-1:0] periodo;
    logic         pronto;
    logic         estouro;
    logic         medindo;

    int compared   = 0;
    int mismatched = 0;
    int prontos    = 0;
    bit chk_on     = 1'b0;

    // Reference model: sampled beat history and the timestamp of the edge that opened the interval
    int ciclo    = 0;
    int m_inicio = 0;
    int el;
    bit ev;
    bit b1, b2, b3;
    bit m_ativo, m_pronto, m_estouro;
    int m_periodo;

    always #5 clock = ~clock;

    medidor_periodo #(.N(N), .MIN(MIN)) dut (
        .clock    (clock),
        .zera_as  (zera_as),
        .zera_s   (zera_s),
        .habilita (habilita),
        .batida   (batida),
        .periodo  (periodo),
        .pronto   (pronto),
        .estouro  (estouro),
        .medindo  (medindo)
    );

    task automatic model_clear();
        b1 = 0; b2 = 0; b3 = 0;
        m_ativo = 0; m_pronto = 0; m_estouro = 0; m_periodo = 0;
    endtask

    // Model step: an edge sampled at clock k acts at clock k+2; period = difference of acting clocks
    always @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            model_clear();
        end else begin
            ciclo++;
            if (zera_s) begin
                model_clear();
            end else begin
                ev = b2 && !b3;
                b3 = b2; b2 = b1; b1 = batida;
                m_pronto = 0;
                if (!habilita) begin
                    m_ativo = 0;
                end else if (m_ativo) begin
                    el = ciclo - m_inicio;
                    if (ev && el >= MIN) begin
                        m_periodo = el;
                        m_pronto  = 1;
                        m_estouro = 0;
                        m_inicio  = ciclo;
                    end else if (el == MAXP) begin
                        m_ativo   = 0;
                        m_estouro = 1;
                    end
                end else if (ev) begin
                    m_ativo  = 1;
                    m_inicio = ciclo;
                end
            end
        end
    end

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        compared++;
        if (atual !== esperado) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", nome, $time, atual, esperado);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_on) begin
            if (pronto) prontos++;
            checkOutput("periodo", 32'(periodo), 32'(m_periodo));
            checkOutput("pronto",  32'(pronto),  32'(m_pronto));
            checkOutput("estouro", 32'(estouro), 32'(m_estouro));
            checkOutput("medindo", 32'(medindo), 32'(m_ativo));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One beat pulse of the given width, then wait so the next pulse starts gap cycles later
    task automatic applyStimulus(input int gap, input int largura);
        batida = 1'b1;
        tick(largura);
        batida = 1'b0;
        tick(gap - largura);
    endtask

    task automatic reinicia_medida();
        habilita = 1'b0;
        tick(2);
        habilita = 1'b1;
        prontos = 0;
    endtask

    task automatic fase_aleatoria();
        int gap;
        int larg;
        int sel;
        for (int r = 0; r < 80; r++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                habilita = 1'b0;
                tick(int'($urandom_range(1, 5)));
                habilita = 1'b1;
            end else if (sel == 1) begin
                zera_s = 1'b1;
                tick(1);
                zera_s = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(250, 262));
            else gap = int'($urandom_range(2, 30));
            larg = (gap > 2) ? int'($urandom_range(1, 2)) : 1;
            applyStimulus(gap, larg);
        end
    endtask

    initial begin
        tick(3);
        zera_as = 1'b0;
        chk_on  = 1'b1;
        checkOutput("reset_periodo", 32'(periodo), 32'd0);
        checkOutput("reset_pronto",  32'(pronto),  32'd0);
        checkOutput("reset_estouro", 32'(estouro), 32'd0);
        checkOutput("reset_medindo", 32'(medindo), 32'd0);

        $display("[TB] steady beat, period 10");
        habilita = 1'b1;
        prontos  = 0;
        for (int i = 0; i < 3; i++) applyStimulus(10, 1);
        batida = 1'b1;
        tick(1);
        batida = 1'b0;
        tick(1);
        checkOutput("latencia_antes", 32'(pronto), 32'd0);
        tick(1);
        checkOutput("latencia_pronto", 32'(pronto), 32'd1);
        checkOutput("steady_periodo", 32'(periodo), 32'd10);
        tick(5);
        checkOutput("steady_strobes", 32'(prontos), 32'd3);

        $display("[TB] bounce");
        reinicia_medida();
        applyStimulus(2, 1);
        applyStimulus(10, 1);
        applyStimulus(5, 1);
        checkOutput("bounce_strobes", 32'(prontos), 32'd1);
        checkOutput("bounce_periodo", 32'(periodo), 32'd12);

        $display("[TB] overflow");
        reinicia_medida();
        applyStimulus(300, 1);
        checkOutput("ovf_estouro", 32'(estouro), 32'd1);
        checkOutput("ovf_medindo", 32'(medindo), 32'd0);
        checkOutput("ovf_periodo", 32'(periodo), 32'd12);
        applyStimulus(20, 1);
        applyStimulus(5, 1);
        checkOutput("ovf_rec_periodo", 32'(periodo), 32'd20);
        checkOutput("ovf_rec_estouro", 32'(estouro), 32'd0);

        $display("[TB] boundaries");
        reinicia_medida();
        applyStimulus(255, 1);
        applyStimulus(5, 1);
        checkOutput("max_periodo", 32'(periodo), 32'd255);
        checkOutput("max_estouro", 32'(estouro), 32'd0);
        checkOutput("max_strobes", 32'(prontos), 32'd1);
        reinicia_medida();
        applyStimulus(4, 1);
        applyStimulus(5, 1);
        checkOutput("min_periodo", 32'(periodo), 32'd4);
        reinicia_medida();
        applyStimulus(3, 1);
        applyStimulus(5, 1);
        checkOutput("curto_strobes", 32'(prontos), 32'd0);
        checkOutput("curto_periodo", 32'(periodo), 32'd4);

        $display("[TB] enable drop and synchronous clear");
        reinicia_medida();
        applyStimulus(6, 1);
        checkOutput("hab_medindo", 32'(medindo), 32'd1);
        habilita = 1'b0;
        tick(2);
        checkOutput("hab_espera", 32'(medindo), 32'd0);
        checkOutput("hab_periodo", 32'(periodo), 32'd4);
        habilita = 1'b1;
        prontos  = 0;
        applyStimulus(8, 1);
        batida = 1'b1;
        tick(1);
        batida = 1'b0;
        tick(1);
        zera_s = 1'b1;
        tick(1);
        zera_s = 1'b0;
        checkOutput("zs_pronto",  32'(pronto),  32'd0);
        checkOutput("zs_periodo", 32'(periodo), 32'd0);
        checkOutput("zs_medindo", 32'(medindo), 32'd0);
        tick(3);
        checkOutput("zs_strobes", 32'(prontos), 32'd0);

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(6, 1);
        applyStimulus(6, 1);
        tick(3);
        zera_as = 1'b1;
        #1;
        checkOutput("as_periodo", 32'(periodo), 32'd0);
        checkOutput("as_medindo", 32'(medindo), 32'd0);
        checkOutput("as_estouro", 32'(estouro), 32'd0);
        @(posedge clock);
        #1;
        zera_as = 1'b0;
        prontos = 0;
        applyStimulus(5, 1);
        checkOutput("as_primeira_borda", 32'(prontos), 32'd0);
        checkOutput("as_conta", 32'(medindo), 32'd1);

        $display("[TB] random beats");
        fase_aleatoria();
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
